// File: rtl/game_io_pkg.sv
// rtl/game_io_pkg.sv - shared address map, CTRL/STATUS bit indices and winner width helper
package game_io_pkg;

    // Word address map
    localparam int ADDR_CTRL        = 0;
    localparam int ADDR_FRAME_CNT   = 1;
    localparam int ADDR_SH_BALL_X   = 2;
    localparam int ADDR_SH_BALL_Y   = 3;
    localparam int ADDR_SH_WINNER   = 4;
    localparam int ADDR_BALL_XLIM   = 5;
    localparam int ADDR_BALL_YLIM   = 6;
    localparam int ADDR_PLAYER_BASE = 8;
    localparam int PLAYER_STRIDE    = 6;

    // Field offsets inside one player's block
    localparam int PF_PAD_LEFT   = 0;
    localparam int PF_PAD_RIGHT  = 1;
    localparam int PF_PAD_TOP    = 2;
    localparam int PF_PAD_BOTTOM = 3;
    localparam int PF_SEG_TOP    = 4;
    localparam int PF_SEG_BOTTOM = 5;

    // CTRL (write) / STATUS (read) bit positions
    localparam int BIT_COMMIT = 0;
    localparam int BIT_READY  = 1;
    localparam int BIT_SERVE  = 2;

    // Winner encoding: 0 = none, 1..num_players = player id
    function automatic int win_w(input int num_players);
        return $clog2(num_players + 1);
    endfunction

endpackage

// File: rtl/shadow_commit_reg.sv
// rtl/shadow_commit_reg.sv - CPU shadow register plus display-visible copy
// Ports: clock/reset (async high); wr/wdata write the shadow; commit copies
// shadow->visible; load_init forces both to init. A CPU write beats load_init
// on the shadow; load_init beats commit on the visible copy. Commit always
// uses the pre-edge shadow value.
module shadow_commit_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         commit,
    input  logic         load_init,
    input  logic [W-1:0] init,
    output logic [W-1:0] shadow,
    output logic [W-1:0] visible
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            visible <= '0;
        end else begin
            if (wr)
                shadow <= wdata;
            else if (load_init)
                shadow <= init;

            if (load_init)
                visible <= init;
            else if (commit)
                visible <= shadow;
        end
    end

endmodule

// File: rtl/frame_sync_game_io.sv
// rtl/frame_sync_game_io.sv - frame-synchronised memory-mapped game I/O bank
// Ports: clock/reset (async high); posEdgeScreenEnd frame strobe; io_we/io_addr/
// io_wdata/io_rdata CPU port (combinational read); ball/paddle/segment live
// inputs; ball_x/ball_y/winner committed display outputs; frame_ready flag.
module frame_sync_game_io
    import game_io_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int FCNT_W      = 16,
    parameter int WIN_W       = win_w(NUM_PLAYERS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       posEdgeScreenEnd,
    input  logic                       io_we,
    input  logic [ADDR_W-1:0]          io_addr,
    input  logic [DATA_W-1:0]          io_wdata,
    output logic [DATA_W-1:0]          io_rdata,
    input  logic [X_W-1:0]             ball_xinit,
    input  logic [Y_W-1:0]             ball_yinit,
    input  logic [X_W-1:0]             ball_xlim,
    input  logic [Y_W-1:0]             ball_ylim,
    input  logic [NUM_PLAYERS*X_W-1:0] pad_left,
    input  logic [NUM_PLAYERS*X_W-1:0] pad_right,
    input  logic [NUM_PLAYERS*Y_W-1:0] pad_top,
    input  logic [NUM_PLAYERS*Y_W-1:0] pad_bottom,
    input  logic [NUM_PLAYERS*Y_W-1:0] seg_top,
    input  logic [NUM_PLAYERS*Y_W-1:0] seg_bottom,
    output logic [X_W-1:0]             ball_x,
    output logic [Y_W-1:0]             ball_y,
    output logic [WIN_W-1:0]           winner,
    output logic                       frame_ready
);

    logic [31:0] addr_ext;
    assign addr_ext = 32'(io_addr);

    logic ctrl_we, sh_x_we, sh_y_we, sh_win_we;
    assign ctrl_we   = io_we && (addr_ext == ADDR_CTRL);
    assign sh_x_we   = io_we && (addr_ext == ADDR_SH_BALL_X);
    assign sh_y_we   = io_we && (addr_ext == ADDR_SH_BALL_Y);
    assign sh_win_we = io_we && (addr_ext == ADDR_SH_WINNER);

    logic              commit_pending, serve_pending, ready;
    logic [FCNT_W-1:0] frame_cnt;
    logic              do_commit, do_serve;

    // Decisions use the pre-edge pending flags; serve overrides commit inside
    // the shadow registers.
    assign do_serve  = posEdgeScreenEnd && serve_pending;
    assign do_commit = posEdgeScreenEnd && commit_pending;

    // A CTRL set in the strobe cycle wins over the strobe's clear, while the
    // strobe's set of ready wins over a CTRL clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_pending <= 1'b0;
            serve_pending  <= 1'b1;
            ready          <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            if (posEdgeScreenEnd)
                frame_cnt <= frame_cnt + FCNT_W'(1);

            if (posEdgeScreenEnd)
                ready <= 1'b1;
            else if (ctrl_we && io_wdata[BIT_READY])
                ready <= 1'b0;

            if (ctrl_we && io_wdata[BIT_COMMIT])
                commit_pending <= 1'b1;
            else if (posEdgeScreenEnd)
                commit_pending <= 1'b0;

            if (ctrl_we && io_wdata[BIT_SERVE])
                serve_pending <= 1'b1;
            else if (posEdgeScreenEnd)
                serve_pending <= 1'b0;
        end
    end

    assign frame_ready = ready;

    logic [X_W-1:0]   sh_x;
    logic [Y_W-1:0]   sh_y;
    logic [WIN_W-1:0] sh_win;

    shadow_commit_reg #(.W(X_W)) u_ball_x (
        .clock(clock), .reset(reset), .wr(sh_x_we), .wdata(io_wdata[X_W-1:0]),
        .commit(do_commit), .load_init(do_serve), .init(ball_xinit),
        .shadow(sh_x), .visible(ball_x)
    );

    shadow_commit_reg #(.W(Y_W)) u_ball_y (
        .clock(clock), .reset(reset), .wr(sh_y_we), .wdata(io_wdata[Y_W-1:0]),
        .commit(do_commit), .load_init(do_serve), .init(ball_yinit),
        .shadow(sh_y), .visible(ball_y)
    );

    shadow_commit_reg #(.W(WIN_W)) u_winner (
        .clock(clock), .reset(reset), .wr(sh_win_we), .wdata(io_wdata[WIN_W-1:0]),
        .commit(do_commit), .load_init(do_serve), .init(WIN_W'(0)),
        .shadow(sh_win), .visible(winner)
    );

    logic [X_W-1:0] xlim_q;
    logic [Y_W-1:0] ylim_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xlim_q <= '0;
            ylim_q <= '0;
        end else if (posEdgeScreenEnd) begin
            xlim_q <= ball_xlim;
            ylim_q <= ball_ylim;
        end
    end

    // Each player block drives zero unless the address hits it, so the
    // per-player read contributions can simply be OR-ed.
    logic [NUM_PLAYERS-1:0][DATA_W-1:0] player_rd;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int BASE = ADDR_PLAYER_BASE + p * PLAYER_STRIDE;

        logic [X_W-1:0]    left_q, right_q;
        logic [Y_W-1:0]    top_q, bottom_q, seg_top_q, seg_bottom_q;
        logic [DATA_W-1:0] rd;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                left_q       <= '0;
                right_q      <= '0;
                top_q        <= '0;
                bottom_q     <= '0;
                seg_top_q    <= '0;
                seg_bottom_q <= '0;
            end else if (posEdgeScreenEnd) begin
                left_q       <= pad_left[p*X_W +: X_W];
                right_q      <= pad_right[p*X_W +: X_W];
                top_q        <= pad_top[p*Y_W +: Y_W];
                bottom_q     <= pad_bottom[p*Y_W +: Y_W];
                seg_top_q    <= seg_top[p*Y_W +: Y_W];
                seg_bottom_q <= seg_bottom[p*Y_W +: Y_W];
            end
        end

        always_comb begin
            rd = '0;
            case (addr_ext)
                BASE + PF_PAD_LEFT:   rd = DATA_W'(left_q);
                BASE + PF_PAD_RIGHT:  rd = DATA_W'(right_q);
                BASE + PF_PAD_TOP:    rd = DATA_W'(top_q);
                BASE + PF_PAD_BOTTOM: rd = DATA_W'(bottom_q);
                BASE + PF_SEG_TOP:    rd = DATA_W'(seg_top_q);
                BASE + PF_SEG_BOTTOM: rd = DATA_W'(seg_bottom_q);
                default:              rd = '0;
            endcase
        end

        assign player_rd[p] = rd;
    end

    always_comb begin
        io_rdata = '0;
        case (addr_ext)
            ADDR_CTRL: begin
                io_rdata[BIT_COMMIT] = commit_pending;
                io_rdata[BIT_READY]  = ready;
                io_rdata[BIT_SERVE]  = serve_pending;
            end
            ADDR_FRAME_CNT: io_rdata = DATA_W'(frame_cnt);
            ADDR_SH_BALL_X: io_rdata = DATA_W'(sh_x);
            ADDR_SH_BALL_Y: io_rdata = DATA_W'(sh_y);
            ADDR_SH_WINNER: io_rdata = DATA_W'(sh_win);
            ADDR_BALL_XLIM: io_rdata = DATA_W'(xlim_q);
            ADDR_BALL_YLIM: io_rdata = DATA_W'(ylim_q);
            default: begin
                for (int p = 0; p < NUM_PLAYERS; p++)
                    io_rdata = io_rdata | player_rd[p];
            end
        endcase
    end

    // Only the low bits of write data reach any register.
    logic unused_wdata;
    assign unused_wdata = ^io_wdata;

endmodule

// File: tb/tb_frame_sync_game_io.sv
// tb/tb_frame_sync_game_io.sv - self-checking bench with behavioural frame model
module tb_frame_sync_game_io;

    localparam int NP     = 3;
    localparam int XW     = 10;
    localparam int YW     = 9;
    localparam int FW     = 4;
    localparam int WW     = 2;
    localparam int XMASK  = (1 << XW) - 1;
    localparam int YMASK  = (1 << YW) - 1;
    localparam int WMASK  = (1 << WW) - 1;
    localparam int FMOD   = 1 << FW;

    logic              clock = 1'b0;
    logic              reset;
    logic              strobe;
    logic              io_we;
    logic [5:0]        io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;
    logic [XW-1:0]     ball_xinit, ball_xlim, ball_x;
    logic [YW-1:0]     ball_yinit, ball_ylim, ball_y;
    logic [NP*XW-1:0]  pad_left, pad_right;
    logic [NP*YW-1:0]  pad_top, pad_bottom, seg_top, seg_bottom;
    logic [WW-1:0]     winner;
    logic              frame_ready;

    logic [31:0] live [NP][6];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_bx, m_by, m_win, m_sx, m_sy, m_sw;
    int m_commit, m_serve, m_ready, m_fcnt, m_xlim, m_ylim;
    int m_snap [NP][6];

    always #5 clock = ~clock;

    always_comb begin
        pad_left = '0; pad_right = '0; pad_top = '0;
        pad_bottom = '0; seg_top = '0; seg_bottom = '0;
        for (int p = 0; p < NP; p++) begin
            pad_left[p*XW +: XW]   = live[p][0][XW-1:0];
            pad_right[p*XW +: XW]  = live[p][1][XW-1:0];
            pad_top[p*YW +: YW]    = live[p][2][YW-1:0];
            pad_bottom[p*YW +: YW] = live[p][3][YW-1:0];
            seg_top[p*YW +: YW]    = live[p][4][YW-1:0];
            seg_bottom[p*YW +: YW] = live[p][5][YW-1:0];
        end
    end

    frame_sync_game_io #(
        .NUM_PLAYERS(NP), .X_W(XW), .Y_W(YW), .DATA_W(32), .ADDR_W(6), .FCNT_W(FW)
    ) dut (
        .clock(clock), .reset(reset), .posEdgeScreenEnd(strobe),
        .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .ball_xinit(ball_xinit), .ball_yinit(ball_yinit),
        .ball_xlim(ball_xlim), .ball_ylim(ball_ylim),
        .pad_left(pad_left), .pad_right(pad_right),
        .pad_top(pad_top), .pad_bottom(pad_bottom),
        .seg_top(seg_top), .seg_bottom(seg_bottom),
        .ball_x(ball_x), .ball_y(ball_y), .winner(winner), .frame_ready(frame_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bx = 0; m_by = 0; m_win = 0; m_sx = 0; m_sy = 0; m_sw = 0;
        m_commit = 0; m_serve = 1; m_ready = 0; m_fcnt = 0; m_xlim = 0; m_ylim = 0;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 6; k++)
                m_snap[p][k] = 0;
    endtask

    function automatic int model_read(input int a);
        if (a == 0) return m_commit + 2 * m_ready + 4 * m_serve;
        if (a == 1) return m_fcnt;
        if (a == 2) return m_sx;
        if (a == 3) return m_sy;
        if (a == 4) return m_sw;
        if (a == 5) return m_xlim;
        if (a == 6) return m_ylim;
        if (a >= 8 && a < 8 + 6 * NP) return m_snap[(a - 8) / 6][(a - 8) % 6];
        return 0;
    endfunction

    // One clock: apply CPU access/strobe, check the read before the edge,
    // advance the model, check the display outputs after the edge.
    task automatic cycle(input bit we, input int addr, input logic [31:0] wd, input bit st);
        int sx0, sy0, sw0, serve0, commit0;
        io_we = we; io_addr = 6'(addr); io_wdata = wd; strobe = st;
        #1;
        chk("rdata", io_rdata, 32'(model_read(addr)));
        sx0 = m_sx; sy0 = m_sy; sw0 = m_sw; serve0 = m_serve; commit0 = m_commit;
        if (st) begin
            for (int p = 0; p < NP; p++)
                for (int k = 0; k < 6; k++)
                    m_snap[p][k] = int'(live[p][k]);
            m_xlim = int'(ball_xlim);
            m_ylim = int'(ball_ylim);
            m_fcnt = (m_fcnt + 1) % FMOD;
            m_ready = 1;
            if (serve0 != 0) begin
                m_bx = int'(ball_xinit); m_by = int'(ball_yinit); m_win = 0;
                m_sx = int'(ball_xinit); m_sy = int'(ball_yinit); m_sw = 0;
                m_serve = 0; m_commit = 0;
            end else if (commit0 != 0) begin
                m_bx = sx0; m_by = sy0; m_win = sw0;
                m_commit = 0;
            end
        end else if (we && addr == 0 && wd[1]) begin
            m_ready = 0;
        end
        if (we) begin
            case (addr)
                0: begin
                    if (wd[0]) m_commit = 1;
                    if (wd[2]) m_serve = 1;
                end
                2: m_sx = int'(wd) & XMASK;
                3: m_sy = int'(wd) & YMASK;
                4: m_sw = int'(wd) & WMASK;
                default: ;
            endcase
        end
        @(posedge clock);
        #1;
        io_we = 1'b0; strobe = 1'b0;
        chk("ball_x", 32'(ball_x), 32'(m_bx));
        chk("ball_y", 32'(ball_y), 32'(m_by));
        chk("winner", 32'(winner), 32'(m_win));
        chk("frame_ready", 32'(frame_ready), 32'(m_ready));
    endtask

    initial begin
        reset = 1'b1; strobe = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
        ball_xinit = '0; ball_yinit = '0; ball_xlim = '0; ball_ylim = '0;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 6; k++)
                live[p][k] = '0;
        model_reset();
        #12;
        chk("rst_ball_x", 32'(ball_x), 0);
        chk("rst_winner", 32'(winner), 0);
        chk("rst_status", io_rdata, 32'd4);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // first strobe serves the ball
        ball_xinit = 10'd320; ball_yinit = 9'd240;
        cycle(0, 0, 0, 1);
        chk("serve_x", 32'(ball_x), 32'd320);
        chk("serve_y", 32'(ball_y), 32'd240);
        chk("status_after_serve", io_rdata, 32'd2);

        // commit only at frame end
        cycle(1, 2, 32'd100, 0);
        cycle(1, 0, 32'd1, 0);
        chk("hold_x", 32'(ball_x), 32'd320);
        cycle(0, 0, 0, 1);
        chk("commit_x", 32'(ball_x), 32'd100);
        chk("commit_clr", 32'(io_rdata[0]), 0);

        // snapshot coherence for player 2 pad_top (address 22)
        live[2][2] = 32'd77;
        cycle(0, 22, 0, 0);
        cycle(0, 22, 0, 1);
        chk("snap_p2_top", io_rdata, 32'd77);
        live[2][2] = 32'd5;
        cycle(0, 22, 0, 0);
        chk("snap_p2_hold", io_rdata, 32'd77);

        // CTRL commit set in the strobe cycle stays pending for the next frame
        cycle(1, 4, 32'd2, 0);
        cycle(1, 0, 32'd1, 1);
        chk("win_same_cycle", 32'(winner), 0);
        cycle(0, 0, 0, 1);
        chk("win_next_frame", 32'(winner), 32'd2);

        // CTRL ready clear in the strobe cycle loses
        cycle(1, 0, 32'd2, 1);
        chk("ready_clear_loses", 32'(frame_ready), 32'd1);

        // frame counter wrap
        for (int i = 0; i < 2 * FMOD && m_fcnt != FMOD - 1; i++)
            cycle(0, 1, 0, 1);
        chk("fcnt_max", io_rdata, 32'(FMOD - 1));
        cycle(0, 1, 0, 1);
        chk("fcnt_wrap", io_rdata, 0);

        // asynchronous reset mid-frame with a commit pending
        cycle(1, 2, 32'd55, 0);
        cycle(1, 0, 32'd1, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_ball_x", 32'(ball_x), 0);
        chk("arst_ball_y", 32'(ball_y), 0);
        chk("arst_ready", 32'(frame_ready), 0);
        chk("arst_status", io_rdata, 32'd4);
        model_reset();
        #1 reset = 1'b0;
        ball_xinit = 10'd11; ball_yinit = 9'd22;
        cycle(0, 0, 0, 1);
        chk("arst_serve_x", 32'(ball_x), 32'd11);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int p = 0; p < NP; p++)
                    for (int k = 0; k < 6; k++)
                        live[p][k] = $urandom & ((k < 2) ? XMASK : YMASK);
                ball_xinit = XW'($urandom);
                ball_yinit = YW'($urandom);
                ball_xlim  = XW'($urandom);
                ball_ylim  = YW'($urandom);
            end
            cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 31),
                  $urandom, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
